// File: rtl/decode_stage_fwd.sv
// RV32I decode stage: register file, operand forwarding, hazard detection,
// branch/jump resolution in ID, and an ID/EX register with hold, bubble and flush.
module decode_stage_fwd #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit FWD_EN = 1'b1,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_ex_stall,
    input  logic            i_flush,
    input  logic            i_mem_we,
    input  logic [RW-1:0]   i_mem_rd_num,
    input  logic [XLEN-1:0] i_mem_val,
    input  logic            i_wb_we,
    input  logic [RW-1:0]   i_wb_rd_num,
    input  logic [XLEN-1:0] i_wb_rd,
    output logic            o_stall,
    output logic            o_b_taken,
    output logic [XLEN-1:0] o_b_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs_1,
    output logic [XLEN-1:0] o_rs_2,
    output logic [RW-1:0]   o_rd_num,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_func_3,
    output logic [6:0]      o_func_7,
    output logic [XLEN-1:0] o_imm
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs_1;
        logic [XLEN-1:0] rs_2;
        logic [RW-1:0]   rd_num;
        logic [6:0]      opcode;
        logic [2:0]      func_3;
        logic [6:0]      func_7;
        logic [XLEN-1:0] imm;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    idex_t           idex_q;
    idex_t           idex_d;

    logic [6:0]      opcode;
    logic [2:0]      func_3;
    logic [6:0]      func_7;
    logic [RW-1:0]   src_num [2];
    logic [XLEN-1:0] src_val [2];
    logic [1:0]      src_use;
    logic [1:0]      ex_hit;
    logic [1:0]      mem_hit;
    logic            is_ctl;
    logic            hz;
    logic            adv;
    logic            cond;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;

    assign opcode     = i_inst[6:0];
    assign func_3     = i_inst[14:12];
    assign func_7     = i_inst[31:25];
    assign src_num[0] = i_inst[15 +: RW];
    assign src_num[1] = i_inst[20 +: RW];
    assign src_use[0] = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign src_use[1] = opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP;

    // Unused sources and x0 read as zero and can never raise a hazard.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic live;
            assign live        = src_use[gi] && (src_num[gi] != '0);
            assign ex_hit[gi]  = live && idex_q.valid && (idex_q.rd_num == src_num[gi]);
            assign mem_hit[gi] = live && i_mem_we && (i_mem_rd_num == src_num[gi]);
            assign src_val[gi] = !live                               ? '0 :
                                 (FWD_EN && mem_hit[gi])             ? i_mem_val :
                                 (i_wb_we && i_wb_rd_num == src_num[gi]) ? i_wb_rd :
                                 rf_q[src_num[gi]];
        end
    endgenerate

    assign is_ctl = (opcode == OP_BRANCH) || (opcode == OP_JALR);
    assign hz     = ((|ex_hit) && (idex_q.opcode == OP_LOAD || is_ctl)) ||
                    (!FWD_EN && ((|ex_hit) || (|mem_hit)));

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR: imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            OP_STORE:  imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            OP_BRANCH: imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                                i_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {i_inst[31:12], 12'b0};
            OP_JAL:    imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                                i_inst[30:21], 1'b0};
            default:   imm32 = '0;
        endcase
    end

    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    always_comb begin
        cond   = 1'b0;
        target = i_pc + imm;
        case (opcode)
            OP_BRANCH: begin
                case (func_3)
                    3'b000:  cond = src_val[0] == src_val[1];
                    3'b001:  cond = src_val[0] != src_val[1];
                    3'b100:  cond = $signed(src_val[0]) <  $signed(src_val[1]);
                    3'b101:  cond = $signed(src_val[0]) >= $signed(src_val[1]);
                    3'b110:  cond = src_val[0] <  src_val[1];
                    3'b111:  cond = src_val[0] >= src_val[1];
                    default: cond = 1'b0;
                endcase
            end
            OP_JAL:  cond = 1'b1;
            OP_JALR: begin
                cond   = 1'b1;
                target = (src_val[0] + imm) & ~XLEN'(1);
            end
            default: cond = 1'b0;
        endcase
    end

    assign adv       = i_valid && !hz && !i_ex_stall && !i_flush;
    assign o_stall   = !i_rst && i_valid && (hz || i_ex_stall);
    assign o_b_taken = !i_rst && adv && cond;
    assign o_b_pc    = o_b_taken ? target : '0;

    always_comb begin
        rf_d = rf_q;
        if (i_wb_we && i_wb_rd_num != '0) begin
            rf_d[i_wb_rd_num] = i_wb_rd;
        end
    end

    // Branches and stores have no destination; their rd field is immediate bits.
    always_comb begin
        idex_d = idex_q;
        if (!i_ex_stall) begin
            idex_d = '0;
            if (adv) begin
                idex_d.valid  = 1'b1;
                idex_d.pc     = i_pc;
                idex_d.rs_1   = src_val[0];
                idex_d.rs_2   = src_val[1];
                idex_d.rd_num = (opcode == OP_BRANCH || opcode == OP_STORE) ? '0 : i_inst[7 +: RW];
                idex_d.opcode = opcode;
                idex_d.func_3 = func_3;
                idex_d.func_7 = func_7;
                idex_d.imm    = imm;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rf_q   <= '{default: '0};
            idex_q <= '0;
        end else begin
            rf_q   <= rf_d;
            idex_q <= idex_d;
        end
    end

    assign o_valid  = idex_q.valid;
    assign o_pc     = idex_q.pc;
    assign o_rs_1   = idex_q.rs_1;
    assign o_rs_2   = idex_q.rs_2;
    assign o_rd_num = idex_q.rd_num;
    assign o_opcode = idex_q.opcode;
    assign o_func_3 = idex_q.func_3;
    assign o_func_7 = idex_q.func_7;
    assign o_imm    = idex_q.imm;
endmodule

// File: tb/tb_decode_stage_fwd.sv
// Bench for decode_stage_fwd: a forwarding and a stall-only instance share stimulus
// and are both checked every cycle against a behavioural model, plus directed cases.
module tb_decode_stage_fwd;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OPS [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_ex_stall, i_flush, i_mem_we, i_wb_we;
    logic [31:0] i_inst, i_pc, i_mem_val, i_wb_rd;
    logic [4:0]  i_mem_rd_num, i_wb_rd_num;

    logic        f_stall, f_b_taken, f_valid, n_stall, n_b_taken, n_valid;
    logic [31:0] f_b_pc, f_pc, f_rs_1, f_rs_2, f_imm, n_b_pc, n_pc, n_rs_1, n_rs_2, n_imm;
    logic [4:0]  f_rd_num, n_rd_num;
    logic [6:0]  f_opcode, f_func_7, n_opcode, n_func_7;
    logic [2:0]  f_func_3, n_func_3;

    int vectors = 0;
    int miscompares = 0;

    // Model state: shared register file, one ID/EX image per instance (0 = stall-only, 1 = forwarding)
    logic [31:0] m_rf [32];
    bit          m_v [2];
    logic [31:0] m_pc [2], m_rs1 [2], m_rs2 [2], m_imm [2];
    logic [4:0]  m_rd [2];
    logic [6:0]  m_op [2], m_f7 [2];
    logic [2:0]  m_f3 [2];

    always #5 i_clk = ~i_clk;

    decode_stage_fwd #(.XLEN(32), .NREGS(32), .FWD_EN(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .i_ex_stall(i_ex_stall), .i_flush(i_flush), .i_mem_we(i_mem_we),
        .i_mem_rd_num(i_mem_rd_num), .i_mem_val(i_mem_val), .i_wb_we(i_wb_we),
        .i_wb_rd_num(i_wb_rd_num), .i_wb_rd(i_wb_rd), .o_stall(f_stall),
        .o_b_taken(f_b_taken), .o_b_pc(f_b_pc), .o_valid(f_valid), .o_pc(f_pc),
        .o_rs_1(f_rs_1), .o_rs_2(f_rs_2), .o_rd_num(f_rd_num), .o_opcode(f_opcode),
        .o_func_3(f_func_3), .o_func_7(f_func_7), .o_imm(f_imm)
    );

    decode_stage_fwd #(.XLEN(32), .NREGS(32), .FWD_EN(1'b0)) dut_nf (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .i_ex_stall(i_ex_stall), .i_flush(i_flush), .i_mem_we(i_mem_we),
        .i_mem_rd_num(i_mem_rd_num), .i_mem_val(i_mem_val), .i_wb_we(i_wb_we),
        .i_wb_rd_num(i_wb_rd_num), .i_wb_rd(i_wb_rd), .o_stall(n_stall),
        .o_b_taken(n_b_taken), .o_b_pc(n_b_pc), .o_valid(n_valid), .o_pc(n_pc),
        .o_rs_1(n_rs_1), .o_rs_2(n_rs_2), .o_rd_num(n_rd_num), .o_opcode(n_opcode),
        .o_func_3(n_func_3), .o_func_7(n_func_7), .o_imm(n_imm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdval(input logic [4:0] r, input int k);
        if (r == 0) return 32'd0;
        if (k == 1 && i_mem_we && i_mem_rd_num == r) return i_mem_val;
        if (i_wb_we && i_wb_rd_num == r) return i_wb_rd;
        return m_rf[r];
    endfunction

    function automatic bit ex_dep(input logic [4:0] r, input bit u, input int k);
        return u && r != 0 && m_v[k] && m_rd[k] == r;
    endfunction

    function automatic bit mem_dep(input logic [4:0] r, input bit u);
        return u && r != 0 && i_mem_we && i_mem_rd_num == r;
    endfunction

    task automatic model_cycle();
        logic [6:0]        op;
        logic [4:0]        r1, r2;
        logic [2:0]        f3;
        logic [31:0]       imm, a, b, tgt, e_bpc, hi;
        logic signed [31:0] s;
        bit                u1, u2, exm, memm, hz, adv, cond, e_stall, e_taken;
        string             tag;
        if (i_rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            for (int k = 0; k < 2; k++) begin
                m_v[k] = 0; m_pc[k] = 0; m_rs1[k] = 0; m_rs2[k] = 0; m_imm[k] = 0;
                m_rd[k] = 0; m_op[k] = 0; m_f7[k] = 0; m_f3[k] = 0;
            end
        end
        op = i_inst[6:0];
        r1 = i_inst[19:15];
        r2 = i_inst[24:20];
        f3 = i_inst[14:12];
        s  = i_inst;
        u1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        u2 = op inside {OP_BRANCH, OP_STORE, OP_OP};
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR: imm = s >>> 20;
            OP_STORE: begin
                hi  = s >>> 20;
                imm = (hi & ~32'h1F) | {27'd0, i_inst[11:7]};
            end
            OP_BRANCH: begin
                hi  = s >>> 19;
                imm = (hi & ~32'hFFF) | {20'd0, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: imm = {i_inst[31:12], 12'd0};
            OP_JAL: begin
                hi  = s >>> 11;
                imm = (hi & ~32'hFFFFF) | {12'd0, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            end
            default: imm = 0;
        endcase
        for (int k = 0; k < 2; k++) begin
            tag  = (k == 1) ? "fwd" : "nofwd";
            a    = u1 ? rdval(r1, k) : 32'd0;
            b    = u2 ? rdval(r2, k) : 32'd0;
            exm  = ex_dep(r1, u1, k) || ex_dep(r2, u2, k);
            memm = mem_dep(r1, u1) || mem_dep(r2, u2);
            hz   = exm && (m_op[k] == OP_LOAD || op == OP_BRANCH || op == OP_JALR);
            if (k == 0 && (exm || memm)) hz = 1;
            cond = 0;
            if (op == OP_JAL || op == OP_JALR) cond = 1;
            if (op == OP_BRANCH) begin
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = ($signed(a) < $signed(b));
                    3'd5: cond = ($signed(a) >= $signed(b));
                    3'd6: cond = (a < b);
                    3'd7: cond = (a >= b);
                    default: cond = 0;
                endcase
            end
            tgt     = (op == OP_JALR) ? ((a + imm) & 32'hFFFF_FFFE) : (i_pc + imm);
            adv     = i_valid && !hz && !i_ex_stall && !i_flush;
            e_stall = !i_rst && i_valid && (hz || i_ex_stall);
            e_taken = !i_rst && adv && cond;
            e_bpc   = e_taken ? tgt : 32'd0;
            chk($sformatf("%s.stall", tag),   k ? f_stall   : n_stall,   e_stall);
            chk($sformatf("%s.b_taken", tag), k ? f_b_taken : n_b_taken, e_taken);
            chk($sformatf("%s.b_pc", tag),    k ? f_b_pc    : n_b_pc,    e_bpc);
            chk($sformatf("%s.valid", tag),   k ? f_valid   : n_valid,   m_v[k]);
            chk($sformatf("%s.pc", tag),      k ? f_pc      : n_pc,      m_pc[k]);
            chk($sformatf("%s.rs_1", tag),    k ? f_rs_1    : n_rs_1,    m_rs1[k]);
            chk($sformatf("%s.rs_2", tag),    k ? f_rs_2    : n_rs_2,    m_rs2[k]);
            chk($sformatf("%s.rd_num", tag),  k ? f_rd_num  : n_rd_num,  m_rd[k]);
            chk($sformatf("%s.opcode", tag),  k ? f_opcode  : n_opcode,  m_op[k]);
            chk($sformatf("%s.func_3", tag),  k ? f_func_3  : n_func_3,  m_f3[k]);
            chk($sformatf("%s.func_7", tag),  k ? f_func_7  : n_func_7,  m_f7[k]);
            chk($sformatf("%s.imm", tag),     k ? f_imm     : n_imm,     m_imm[k]);
            if (!i_rst && !i_ex_stall) begin
                m_v[k]   = adv;
                m_pc[k]  = adv ? i_pc : 32'd0;
                m_rs1[k] = adv ? a : 32'd0;
                m_rs2[k] = adv ? b : 32'd0;
                m_rd[k]  = (adv && !(op inside {OP_BRANCH, OP_STORE})) ? i_inst[11:7] : 5'd0;
                m_op[k]  = adv ? op : 7'd0;
                m_f3[k]  = adv ? f3 : 3'd0;
                m_f7[k]  = adv ? i_inst[31:25] : 7'd0;
                m_imm[k] = adv ? imm : 32'd0;
            end
        end
        if (!i_rst && i_wb_we && i_wb_rd_num != 0) m_rf[i_wb_rd_num] = i_wb_rd;
    endtask

    always @(negedge i_clk) model_cycle();

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, OP_OP};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom();
        x[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom()) : OPS[$urandom_range(0, 8)];
        x[11:7]  = 5'($urandom_range(0, 7));
        x[19:15] = 5'($urandom_range(0, 7));
        x[24:20] = 5'($urandom_range(0, 7));
        return x;
    endfunction

    function automatic logic [31:0] rand_val();
        return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom());
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        i_valid = 0; i_inst = 0; i_pc = 0; i_ex_stall = 0; i_flush = 0;
        i_mem_we = 0; i_mem_rd_num = 0; i_mem_val = 0;
        i_wb_we = 0; i_wb_rd_num = 0; i_wb_rd = 0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        i_wb_we = 1; i_wb_rd_num = r; i_wb_rd = v;
        cyc();
        i_wb_we = 0;
    endtask

    initial begin
        i_rst = 1;
        set_idle();
        cyc(); cyc();
        chk("rst.valid", f_valid, 0);
        chk("rst.stall", f_stall, 0);
        chk("rst.rs_1", f_rs_1, 0);
        i_rst = 0;

        // Write-through bypass then register-file read
        i_wb_we = 1; i_wb_rd_num = 5; i_wb_rd = 32'h1234;
        i_valid = 1; i_pc = 32'h10; i_inst = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OP_OPIMM);
        #2 chk("wr.stall", f_stall, 0);
        cyc();
        chk("wr.rs_1", f_rs_1, 32'h1234);
        chk("wr.imm", f_imm, 1);
        chk("wr.valid", f_valid, 1);
        chk("wr.rd_num", f_rd_num, 6);
        i_wb_rd_num = 0; i_wb_rd = 32'hFFFF;
        i_pc = 32'h14; i_inst = enc_i(12'd0, 5'd0, 3'd0, 5'd1, OP_OPIMM);
        cyc();
        chk("x0.rs_1", f_rs_1, 0);
        i_valid = 0; i_wb_we = 0;
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        wb_write(5'd9, 32'h201);

        // EX/MEM forward vs. stall-only instance
        i_valid = 1; i_pc = 32'h18; i_inst = enc_r(5'd2, 5'd1, 5'd3);
        i_mem_we = 1; i_mem_rd_num = 1; i_mem_val = 32'hAA;
        #2;
        chk("fwd.stall", f_stall, 0);
        chk("nofwd.stall", n_stall, 1);
        cyc();
        chk("fwd.rs_1", f_rs_1, 32'hAA);
        chk("fwd.rs_2", f_rs_2, 7);
        chk("fwd.valid", f_valid, 1);
        chk("nofwd.bubble", n_valid, 0);
        i_mem_we = 0;

        // Load-use
        i_pc = 32'h20; i_inst = enc_i(12'd0, 5'd1, 3'd2, 5'd4, OP_LOAD);
        cyc();
        i_pc = 32'h24; i_inst = enc_r(5'd4, 5'd4, 5'd7);
        #2 chk("lu.stall1", f_stall, 1);
        cyc();
        chk("lu.bubble", f_valid, 0);
        #2 chk("lu.stall2", f_stall, 0);
        cyc();
        chk("lu.valid", f_valid, 1);
        chk("lu.rd_num", f_rd_num, 7);

        // Branch resolution
        i_pc = 32'h100; i_inst = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0);
        #2;
        chk("beq.taken", f_b_taken, 1);
        chk("beq.b_pc", f_b_pc, 32'hF8);
        cyc();
        i_pc = 32'h104; i_inst = enc_i(12'd12, 5'd9, 3'd0, 5'd0, OP_JALR);
        #2;
        chk("jalr.taken", f_b_taken, 1);
        chk("jalr.b_pc", f_b_pc, 32'h20C);
        cyc();
        i_pc = 32'h108; i_inst = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1);
        #2;
        chk("bne.taken", f_b_taken, 0);
        chk("bne.b_pc", f_b_pc, 0);
        cyc();

        // Hold under downstream stall, flush during hold, flush of a taken branch
        i_pc = 32'h300; i_inst = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OP_OPIMM);
        cyc();
        i_pc = 32'h304; i_inst = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0);
        i_ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            i_flush = (i == 1);
            #2;
            chk("hold.taken", f_b_taken, 0);
            chk("hold.stall", f_stall, 1);
            cyc();
            chk("hold.valid", f_valid, 1);
            chk("hold.pc", f_pc, 32'h300);
            chk("hold.rs_1", f_rs_1, 32'h1234);
        end
        i_ex_stall = 0; i_flush = 1;
        #2 chk("flush.taken", f_b_taken, 0);
        cyc();
        chk("flush.bubble", f_valid, 0);
        i_flush = 0;

        // Asynchronous reset in the middle of a stall
        i_pc = 32'h400; i_inst = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OP_OPIMM);
        cyc();
        i_pc = 32'h404; i_inst = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0); i_ex_stall = 1;
        #2 i_rst = 1;
        #1;
        chk("arst.valid", f_valid, 0);
        chk("arst.pc", f_pc, 0);
        chk("arst.rs_1", f_rs_1, 0);
        chk("arst.stall", f_stall, 0);
        chk("arst.taken", f_b_taken, 0);
        chk("arst.b_pc", f_b_pc, 0);
        cyc();
        i_rst = 0;
        set_idle();
        cyc();
        chk("arst.resume", f_valid, 0);
        i_valid = 1; i_pc = 32'h408; i_inst = enc_i(12'd1, 5'd5, 3'd0, 5'd6, OP_OPIMM);
        cyc();
        chk("arst.rf_clear", f_rs_1, 0);
        chk("arst.issue", f_valid, 1);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            i_rst        = ($urandom_range(0, 499) == 0);
            i_valid      = ($urandom_range(0, 3) != 0);
            i_inst       = rand_inst();
            i_pc         = $urandom() & 32'hFFFF_FFFC;
            i_ex_stall   = ($urandom_range(0, 7) == 0);
            i_flush      = ($urandom_range(0, 9) == 0);
            i_mem_we     = 1'($urandom_range(0, 1));
            i_mem_rd_num = 5'($urandom_range(0, 7));
            i_mem_val    = rand_val();
            i_wb_we      = 1'($urandom_range(0, 1));
            i_wb_rd_num  = 5'($urandom_range(0, 7));
            i_wb_rd      = rand_val();
            cyc();
        end
        i_rst = 0;
        set_idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
